pong_object_ctrl: RTL and testbench
===================================

# pong_object_ctrl

Frame-synchronous motion controller for the three fixed-geometry objects drawn by the graphic generator: wall, ball and paddle. It watches the scan counters from the VGA sync block and detects the start of vertical blanking. During each blanking interval it steps a state machine that moves the paddle from buttons, moves the ball, and resolves bounces, hits and misses. Its registered ball/paddle coordinates feed the graphic generator's object-on comparators, replacing the hard-coded ball and paddle positions.

## Interface
- WALL_X_R, 35: right edge of wall (wall occupies x 32..35)
- PADDLE_X_L, 600: paddle left column
- PADDLE_X_R, 603: paddle right column
- PADDLE_H, 72: paddle height in rows
- PADDLE_V, 4: paddle step per frame
- BALL_SIZE, 8: ball edge length
- BALL_V, 2: ball step per frame per axis
- SERVE_X, 300 / SERVE_Y, 240: ball rest position (top-left)
- SERVE_DELAY, 60: frames before auto-serve (macro only)
- clk  in  1  system clock; one clock
- reset  in  1  asynchronous, active-low reset
- pixel_x  in  10  current scan column from sync block
- pixel_y  in  10  current scan row from sync block
- btn_up, btn_down, btn_serve  in  1 each  debounced level inputs
- ball_x, ball_y  out  10 each  ball top-left coordinate
- paddle_y  out  10  paddle top row
- ball_active  out  1  ball in play; generator hides ball when 0
- hit  out  1  one-clk pulse on paddle hit
- miss  out  1  one-clk pulse on miss

## Operation
- All coordinates are 10-bit unsigned. The ball covers ball_x..ball_x+BALL_SIZE-1, and likewise in y. Ball velocity is held as one direction bit per axis with fixed magnitude BALL_V.
- Frame tick: cond = (pixel_x==0 && pixel_y==481). tick = cond & ~cond_d, giving exactly one clk per frame regardless of the pixel-enable rate.
- IDLE: ball_active=0 and the ball is held at (SERVE_X, SERVE_Y).
  - Paddle still updates on tick.
  - btn_serve=1 → ball_active=1, dir_x=left, dir_y=down, go to WAIT.
- WAIT: on tick → PADDLE.
- PADDLE:
  - up&~down: paddle_y = (paddle_y<PADDLE_V) ? 0 : paddle_y-PADDLE_V.
  - down&~up: paddle_y = min(paddle_y+PADDLE_V, 480-PADDLE_H).
  - Both pressed or neither: hold.
  - Next state is BALL.
- BALL: all checks use pre-move values. New directions apply to the move in the same cycle. Next state is WAIT unless a miss occurs.
  - Top: ball_y<=BALL_V → dir_y=down.
  - Bottom: ball_y+BALL_SIZE-1 >= 479-BALL_V → dir_y=up.
  - Wall: dir_x=left and ball_x<=WALL_X_R+BALL_V → dir_x=right.
  - Hit: all of the following hold → dir_x=left, hit=1.
    - dir_x=right.
    - ball_x+BALL_SIZE-1+BALL_V lies in [PADDLE_X_L, PADDLE_X_R].
    - ball_y+BALL_SIZE-1 >= paddle_y.
    - ball_y <= paddle_y+PADDLE_H-1.
  - Miss: ball_x+BALL_SIZE-1 > PADDLE_X_R → miss=1, no move, go to MISS.
  - A y-bounce and an x-bounce in the same frame (corner) both apply.
- MISS: return the ball to the serve position, ball_active=0, go to IDLE.
- btn_serve is ignored outside IDLE.

## Timing
- Reset values: ball_x=SERVE_X, ball_y=SERVE_Y, paddle_y=240-PADDLE_H/2-1 (=203), ball_active=0, hit=0, miss=0, state=IDLE, dir_x=left, dir_y=down, cond_d=0.
- Latency:
  - tick seen in WAIT at cycle T.
  - paddle_y updates at T+2.
  - ball_x/ball_y, hit and miss update at T+3.
  - All changes fall inside vertical blanking; outputs are stable through active video.
- hit and miss are high for exactly one clk.
- Positions change at most once per frame.
- Reset asserted mid-frame or mid-sequence returns all registers to reset values immediately. The first tick after release is processed normally.

## Configuration
- PONG_AUTO_SERVE_EN defined:
  - MISS loads a 6-bit frame counter with SERVE_DELAY.
  - IDLE decrements the counter on each tick and auto-serves when it reaches 0.
  - btn_serve still serves early.
- PONG_AUTO_SERVE_EN undefined:
  - No counter exists.
  - IDLE waits indefinitely for btn_serve.

## Test plan
- Reset low then high, no buttons, 5 frames → ball_x=300, ball_y=240, paddle_y=203, ball_active=0, no hit or miss pulses.
- Hold btn_up 60 frames → paddle_y steps down by 4 per frame and sticks at 0. Hold btn_down 120 frames → sticks at 408. Both buttons held → unchanged.
- Serve, paddle idle → ball_x falls 2 per frame to 36, then rises to 38 on the next frame. ball_y bounces so that it stays within 2..472.
- Paddle at 203, ball returning right with rows overlapping → hit pulse at T+3 of the frame whose next right edge is 600..603. The next frame's ball_x decreases.
- Paddle at 0, ball at y≈240 moving right → miss pulse when right edge exceeds 603. ball_active=0 and the ball is at (300,240).
  - With PONG_AUTO_SERVE_EN: ball_active=1 after 60 ticks.
  - Without it: ball_active stays 0 until btn_serve.
- Assert reset for 3 clk between tick and T+3 → outputs show reset values immediately, and no hit or miss pulse is emitted.

Source files
------------

// File: rtl/pong_object_ctrl_if.sv
// Scan-position, button and object-position bundle between the sync/input side
// and the pong object controller.
interface pong_object_ctrl_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       btn_up;
    logic       btn_down;
    logic       btn_serve;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] paddle_y;
    logic       ball_active;
    logic       hit;
    logic       miss;

    modport master (
        output pixel_x, pixel_y, btn_up, btn_down, btn_serve,
        input  ball_x, ball_y, paddle_y, ball_active, hit, miss
    );

    modport slave (
        input  pixel_x, pixel_y, btn_up, btn_down, btn_serve,
        output ball_x, ball_y, paddle_y, ball_active, hit, miss
    );
endinterface

// File: rtl/pong_object_ctrl.sv
// Frame-synchronous wall/ball/paddle motion controller, stepped once per vertical blank.
// Optional auto-serve after a miss: define PONG_AUTO_SERVE_EN.
module pong_object_ctrl #(
    parameter int WALL_X_R   = 35,
    parameter int PADDLE_X_L = 600,
    parameter int PADDLE_X_R = 603,
    parameter int PADDLE_H   = 72,
    parameter int PADDLE_V   = 4,
    parameter int BALL_SIZE  = 8,
    parameter int BALL_V     = 2,
    parameter int SERVE_X    = 300,
    parameter int SERVE_Y    = 240
) (
    input  logic              clk,
    input  logic              reset,
    pong_object_ctrl_if.slave bus
);
    localparam logic [9:0] BALL_V_W     = 10'(BALL_V);
    localparam logic [9:0] PADDLE_V_W   = 10'(PADDLE_V);
    localparam logic [9:0] PADDLE_Y_MAX = 10'(480 - PADDLE_H);
    localparam logic [9:0] PADDLE_Y_RST = 10'(240 - PADDLE_H / 2 - 1);
    localparam logic [9:0] BALL_EXT     = 10'(BALL_SIZE - 1);
    localparam logic [9:0] PADDLE_EXT   = 10'(PADDLE_H - 1);
    localparam logic [9:0] BOTTOM_LIM   = 10'(479 - BALL_V);
    localparam logic [9:0] WALL_LIM     = 10'(WALL_X_R + BALL_V);
    localparam logic [9:0] HIT_L        = 10'(PADDLE_X_L);
    localparam logic [9:0] HIT_R        = 10'(PADDLE_X_R);
    localparam logic [9:0] SERVE_X_W    = 10'(SERVE_X);
    localparam logic [9:0] SERVE_Y_W    = 10'(SERVE_Y);
`ifdef PONG_AUTO_SERVE_EN
    localparam logic [5:0] SERVE_DELAY  = 6'd60;
`endif

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PADDLE, S_BALL, S_MISS} state_t;

    state_t     state, state_nxt;
    logic [9:0] ball_x, ball_x_nxt, ball_y, ball_y_nxt, paddle_y, paddle_y_nxt;
    logic       ball_active, ball_active_nxt, hit, hit_nxt, miss, miss_nxt;
    logic       dir_x, dir_x_nxt, dir_y, dir_y_nxt;  // dir_x 1 = right, dir_y 1 = down
    logic       cond, cond_d, tick;
    logic [9:0] paddle_move, ball_bottom, ball_right_next;
    logic       dir_x_bnc, dir_y_bnc, hit_now, miss_now, serve_now;
`ifdef PONG_AUTO_SERVE_EN
    logic [5:0] serve_cnt, serve_cnt_nxt;
`endif

    // Edge-detect the blanking marker so a slow pixel enable still gives one tick per frame.
    assign cond = (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd481);
    assign tick = cond & ~cond_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        paddle_move = paddle_y;
        if (bus.btn_up && !bus.btn_down)
            paddle_move = (paddle_y < PADDLE_V_W) ? 10'd0 : paddle_y - PADDLE_V_W;
        else if (bus.btn_down && !bus.btn_up)
            paddle_move = (paddle_y + PADDLE_V_W > PADDLE_Y_MAX) ? PADDLE_Y_MAX
                                                               : paddle_y + PADDLE_V_W;
    end

    // Bounce, hit and miss decisions all look at the pre-move position.
    always_comb begin
        ball_bottom     = ball_y + BALL_EXT;
        ball_right_next = ball_x + BALL_EXT + BALL_V_W;
        dir_y_bnc       = dir_y;
        dir_x_bnc       = dir_x;
        hit_now         = 1'b0;
        if (ball_y <= BALL_V_W)
            dir_y_bnc = 1'b1;
        else if (ball_bottom >= BOTTOM_LIM)
            dir_y_bnc = 1'b0;
        if (!dir_x && ball_x <= WALL_LIM)
            dir_x_bnc = 1'b1;
        if (dir_x && ball_right_next >= HIT_L && ball_right_next <= HIT_R &&
            ball_bottom >= paddle_y && ball_y <= paddle_y + PADDLE_EXT) begin
            dir_x_bnc = 1'b0;
            hit_now   = 1'b1;
        end
        miss_now = (ball_x + BALL_EXT) > HIT_R;
    end

    always_comb begin
        state_nxt       = state;
        ball_x_nxt      = ball_x;
        ball_y_nxt      = ball_y;
        paddle_y_nxt    = paddle_y;
        ball_active_nxt = ball_active;
        dir_x_nxt       = dir_x;
        dir_y_nxt       = dir_y;
        hit_nxt         = 1'b0;
        miss_nxt        = 1'b0;
        serve_now       = bus.btn_serve;
`ifdef PONG_AUTO_SERVE_EN
        serve_cnt_nxt   = serve_cnt;
        // A zero count means no auto-serve is pending (power-up, or already served).
        if (state == S_IDLE && tick && serve_cnt != 6'd0) begin
            serve_cnt_nxt = serve_cnt - 6'd1;
            if (serve_cnt == 6'd1)
                serve_now = 1'b1;
        end
`endif
        case (state)
            S_IDLE: begin
                ball_x_nxt      = SERVE_X_W;
                ball_y_nxt      = SERVE_Y_W;
                ball_active_nxt = 1'b0;
                if (tick)
                    paddle_y_nxt = paddle_move;
                if (serve_now) begin
                    ball_active_nxt = 1'b1;
                    dir_x_nxt       = 1'b0;
                    dir_y_nxt       = 1'b1;
                    state_nxt       = S_WAIT;
`ifdef PONG_AUTO_SERVE_EN
                    serve_cnt_nxt   = 6'd0;
`endif
                end
            end
            S_WAIT: if (tick) state_nxt = S_PADDLE;
            S_PADDLE: begin
                paddle_y_nxt = paddle_move;
                state_nxt    = S_BALL;
            end
            S_BALL: begin
                if (miss_now) begin
                    miss_nxt  = 1'b1;
                    state_nxt = S_MISS;
                end else begin
                    dir_x_nxt  = dir_x_bnc;
                    dir_y_nxt  = dir_y_bnc;
                    ball_x_nxt = dir_x_bnc ? ball_x + BALL_V_W : ball_x - BALL_V_W;
                    ball_y_nxt = dir_y_bnc ? ball_y + BALL_V_W : ball_y - BALL_V_W;
                    hit_nxt    = hit_now;
                    state_nxt  = S_WAIT;
                end
            end
            S_MISS: begin
                ball_x_nxt      = SERVE_X_W;
                ball_y_nxt      = SERVE_Y_W;
                ball_active_nxt = 1'b0;
                state_nxt       = S_IDLE;
`ifdef PONG_AUTO_SERVE_EN
                serve_cnt_nxt   = SERVE_DELAY;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            ball_x      <= SERVE_X_W;
            ball_y      <= SERVE_Y_W;
            paddle_y    <= PADDLE_Y_RST;
            ball_active <= 1'b0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            dir_x       <= 1'b0;
            dir_y       <= 1'b1;
            cond_d      <= 1'b0;
`ifdef PONG_AUTO_SERVE_EN
            serve_cnt   <= 6'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_nxt;
            ball_x      <= ball_x_nxt;
            ball_y      <= ball_y_nxt;
            paddle_y    <= paddle_y_nxt;
            ball_active <= ball_active_nxt;
            hit         <= hit_nxt;
            miss        <= miss_nxt;
            dir_x       <= dir_x_nxt;
            dir_y       <= dir_y_nxt;
            cond_d      <= cond;
`ifdef PONG_AUTO_SERVE_EN
            serve_cnt   <= serve_cnt_nxt;
`endif
        end
    end

    assign bus.ball_x      = ball_x;
    assign bus.ball_y      = ball_y;
    assign bus.paddle_y    = paddle_y;
    assign bus.ball_active = ball_active;
    assign bus.hit         = hit;
    assign bus.miss        = miss;
endmodule

// File: tb/tb_pong_object_ctrl.sv
// Scoreboard bench for pong_object_ctrl: stimulus queues expected snapshots and
// pulses, independent monitors compare them against the DUT outputs.
module tb_pong_object_ctrl;
    localparam int PERIOD = 10;
`ifdef PONG_AUTO_SERVE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [9:0] bx;
        logic [9:0] by;
        logic [9:0] py;
        logic       act;
    } snap_t;

    typedef struct {
        logic is_hit;
        int   frame;
    } pulse_t;

    logic   clk = 1'b0;
    logic   reset;
    snap_t  snap_q[$];
    pulse_t pulse_q[$];
    int     errors = 0;
    int     checks = 0;
    int     frame_no = 0;
    time    tick_time = 0;
    event   sample_ev;
    snap_t  mon_s;
    pulse_t mon_p;

    always #(PERIOD / 2) clk = ~clk;

    pong_object_ctrl_if bus ();

    pong_object_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Snapshot monitor: compares one queued expectation per sample request.
    initial forever begin
        @(sample_ev);
        @(negedge clk);
        if (snap_q.size() == 0) begin
            check("snap_underflow", 1'b0, "sample requested with empty queue");
        end else begin
            mon_s = snap_q.pop_front();
            check(mon_s.name,
                  {bus.ball_x, bus.ball_y, bus.paddle_y, bus.ball_active} ===
                  {mon_s.bx, mon_s.by, mon_s.py, mon_s.act},
                  $sformatf("got x=%0d y=%0d p=%0d act=%0b, want x=%0d y=%0d p=%0d act=%0b",
                            bus.ball_x, bus.ball_y, bus.paddle_y, bus.ball_active,
                            mon_s.bx, mon_s.by, mon_s.py, mon_s.act));
        end
    end

    // Pulse monitor: every hit/miss cycle must match the next queued pulse.
    always @(negedge clk) begin
        if (bus.hit === 1'b1 || bus.miss === 1'b1) begin
            if (pulse_q.size() == 0) begin
                check("unexpected_pulse", 1'b0,
                      $sformatf("got hit=%0b miss=%0b in frame %0d, want no pulse",
                                bus.hit, bus.miss, frame_no));
            end else begin
                mon_p = pulse_q.pop_front();
                check($sformatf("pulse_frame%0d", mon_p.frame),
                      bus.hit === mon_p.is_hit && bus.miss === !mon_p.is_hit &&
                      frame_no == mon_p.frame && ($time - tick_time) / PERIOD == 3,
                      $sformatf("got hit=%0b miss=%0b frame=%0d offset=%0d, want hit=%0b miss=%0b frame=%0d offset=3",
                                bus.hit, bus.miss, frame_no, ($time - tick_time) / PERIOD,
                                mon_p.is_hit, !mon_p.is_hit, mon_p.frame));
            end
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_snap(input string name, input int bx, input int by,
                               input int py, input bit act);
        snap_t s;
        s.name = name;
        s.bx   = 10'(bx);
        s.by   = 10'(by);
        s.py   = 10'(py);
        s.act  = act;
        snap_q.push_back(s);
        -> sample_ev;
        step();
        step();
    endtask

    task automatic expect_pulse(input bit is_hit);
        pulse_t p;
        p.is_hit = is_hit;
        p.frame  = frame_no + 1;
        pulse_q.push_back(p);
    endtask

    // One short frame: a tick cycle at (0,481), rest of blanking, then two active cycles.
    // abort pulls reset low for 3 clocks starting one clock after the tick.
    task automatic run_frame(input bit abort);
        bus.pixel_x = 10'd0;
        bus.pixel_y = 10'd481;
        frame_no++;
        tick_time = $time;
        step();
        for (int i = 1; i < 8; i++) begin
            bus.pixel_x = 10'(i);
            if (abort && i == 1) reset = 1'b0;
            if (abort && i == 2) begin
                snap_t s;
                s.name = "reset_mid_frame";
                s.bx = 10'd300; s.by = 10'd240; s.py = 10'd203; s.act = 1'b0;
                snap_q.push_back(s);
                -> sample_ev;
            end
            if (abort && i == 4) reset = 1'b1;
            step();
        end
        bus.pixel_x = 10'd0;
        bus.pixel_y = 10'd0;
        step();
        step();
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) run_frame(1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic serve();
        bus.btn_serve = 1'b1;
        step();
        bus.btn_serve = 1'b0;
        step();
    endtask

    initial begin
        reset         = 1'b0;
        bus.pixel_x   = 10'd0;
        bus.pixel_y   = 10'd0;
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_serve = 1'b0;
        step();
        step();
        expect_snap("reset_values", 300, 240, 203, 0);
        reset = 1'b1;
        step();
        run_frames(5);
        expect_snap("idle_5_frames", 300, 240, 203, 0);

        // Paddle limits while idle.
        bus.btn_up = 1'b1;
        run_frames(1);
        expect_snap("up_1", 300, 240, 199, 0);
        run_frames(49);
        expect_snap("up_50", 300, 240, 3, 0);
        run_frames(1);
        expect_snap("up_51_clamp", 300, 240, 0, 0);
        run_frames(9);
        expect_snap("up_60_hold", 300, 240, 0, 0);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b1;
        run_frames(1);
        expect_snap("down_1", 300, 240, 4, 0);
        run_frames(100);
        expect_snap("down_101", 300, 240, 404, 0);
        run_frames(1);
        expect_snap("down_102_clamp", 300, 240, 408, 0);
        run_frames(18);
        expect_snap("down_120_hold", 300, 240, 408, 0);
        bus.btn_up = 1'b1;
        run_frames(5);
        expect_snap("both_hold", 300, 240, 408, 0);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;

        // Trajectory with wall and top/bottom bounces, then reset just before the hit lands.
        do_reset();
        bus.btn_up = 1'b1;
        run_frames(20);
        bus.btn_up = 1'b0;
        expect_snap("paddle_123", 300, 240, 123, 0);
        serve();
        expect_snap("served", 300, 240, 123, 1);
        run_frames(115);
        expect_snap("at_bottom_limit", 70, 470, 123, 1);
        run_frames(1);
        expect_snap("bottom_bounce", 68, 468, 123, 1);
        run_frames(16);
        expect_snap("at_wall", 36, 436, 123, 1);
        run_frames(1);
        expect_snap("wall_bounce", 38, 434, 123, 1);
        run_frames(216);
        expect_snap("at_top_limit", 470, 2, 123, 1);
        run_frames(1);
        expect_snap("top_bounce", 472, 4, 123, 1);
        run_frames(60);
        expect_snap("before_hit", 592, 124, 123, 1);
        run_frame(1'b1);
        expect_snap("after_abort", 300, 240, 203, 0);
        bus.btn_up = 1'b1;
        run_frames(1);
        bus.btn_up = 1'b0;
        expect_snap("first_tick_after_reset", 300, 240, 199, 0);

        // Same trajectory, hit lands this time.
        do_reset();
        bus.btn_up = 1'b1;
        run_frames(20);
        bus.btn_up = 1'b0;
        serve();
        run_frames(410);
        expect_snap("pre_hit", 592, 124, 123, 1);
        expect_pulse(1'b1);
        run_frames(1);
        expect_snap("hit_bounce", 590, 126, 123, 1);
        run_frames(1);
        expect_snap("after_hit", 588, 128, 123, 1);

        // Paddle parked at the top: the ball passes it and misses.
        do_reset();
        bus.btn_up = 1'b1;
        run_frames(51);
        bus.btn_up = 1'b0;
        expect_snap("paddle_top", 300, 240, 0, 0);
        serve();
        run_frames(413);
        expect_snap("pre_miss", 598, 130, 0, 1);
        expect_pulse(1'b0);
        run_frames(1);
        expect_snap("after_miss", 300, 240, 0, 0);
        run_frames(59);
        expect_snap("idle_59", 300, 240, 0, 0);
        run_frames(1);
        expect_snap("idle_60", 300, 240, 0, AUTO);
        serve();
        expect_snap("manual_serve", 300, 240, 0, 1);

        run_frames(2);
        check("pulses_drained", pulse_q.size() == 0,
              $sformatf("got %0d pending pulses, want 0", pulse_q.size()));
        check("snaps_drained", snap_q.size() == 0,
              $sformatf("got %0d pending snapshots, want 0", snap_q.size()));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
